// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous ROM among NREQ requesters.
// A read accepted in cycle T returns a one-hot tagged response in cycle T+2.
module rom_arbiter #(
  parameter int NREQ  = 4,
  parameter int ADDRW = 10,
  parameter int DATAW = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*ADDRW-1:0]   req_addr,
  output logic [NREQ-1:0]         req_ready,
  output logic [ADDRW-1:0]        rom_addr,
  input  logic [DATAW-1:0]        rom_dout,
  output logic [NREQ-1:0]         resp_valid,
  output logic [DATAW-1:0]        resp_data,
  output logic                    busy
);

  localparam int              PTRW   = $clog2(NREQ);
  localparam logic [PTRW:0]   NREQ_W = (PTRW+1)'(NREQ);
  localparam logic [PTRW-1:0] LAST   = PTRW'(NREQ - 1);

  logic [PTRW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0]  g1_q, g1_d;
  logic [NREQ-1:0]  resp_valid_q, resp_valid_d;
  logic [DATAW-1:0] resp_data_q, resp_data_d;
  logic [ADDRW-1:0] last_addr_q, last_addr_d;

  logic [ADDRW-1:0] addr_arr [NREQ];
  logic [NREQ-1:0]  grant;
  logic [PTRW-1:0]  win;
  logic             found;
  logic [PTRW:0]    sum;
  logic [PTRW-1:0]  idx;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[i*ADDRW +: ADDRW];
  end

  // Stage 0: rotating-priority search starting at ptr; grants are suppressed in reset
  always_comb begin
    grant = '0;
    win   = ptr_q;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + (PTRW+1)'(k);
      idx = (sum >= NREQ_W) ? PTRW'(sum - NREQ_W) : PTRW'(sum);
      if (!found && rst_n && req_valid[idx]) begin
        found      = 1'b1;
        win        = idx;
        grant[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d        = ptr_q;
    last_addr_d  = last_addr_q;
    rom_addr     = last_addr_q;
    if (found) begin
      ptr_d       = (win == LAST) ? '0 : win + 1'b1;
      last_addr_d = addr_arr[win];
      rom_addr    = addr_arr[win];
    end
    g1_d         = grant;
    resp_valid_d = g1_q;
    resp_data_d  = (|g1_q) ? rom_dout : resp_data_q;
  end

  // Stage 1 (g1) tracks the ROM access; stage 2 registers the returned data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      g1_q         <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      last_addr_q  <= '0;
    end else begin
      ptr_q        <= ptr_d;
      g1_q         <= g1_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      last_addr_q  <= last_addr_d;
    end
  end

  assign req_ready  = grant;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign busy       = (|g1_q) | (|resp_valid_q);

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a synchronous ROM model (mem[a] = a + 16'h1000)
// and a queue-based response scoreboard.
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [39:0] req_addr;
  logic [3:0]  req_ready;
  logic [9:0]  rom_addr;
  logic [15:0] rom_dout;
  logic [3:0]  resp_valid;
  logic [15:0] resp_data;
  logic        busy;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    logic [3:0]  tag;
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  rom_arbiter #(.NREQ(4), .ADDRW(10), .DATAW(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .rom_addr   (rom_addr),
    .rom_dout   (rom_dout),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_dout <= 16'h1000 + {6'd0, rom_addr};
    cyc      <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        chk("resp_missing_due", 32'(sb[0].due), 32'(cyc));
        void'(sb.pop_front());
      end
      if (resp_valid != 4'b0000) begin
        if (sb.size() == 0) begin
          chk("resp_unexpected", {28'd0, resp_valid}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_tag",     {28'd0, resp_valid}, {28'd0, e.tag});
          chk("resp_data",    {16'd0, resp_data},  {16'd0, e.data});
          chk("resp_latency", 32'(cyc),            32'(e.due));
        end
      end
    end
  end

  task automatic step(input logic [3:0] v, input logic [39:0] a, input logic [3:0] er,
                      input logic [9:0] ea, input logic [15:0] ed, input bit push);
    req_valid = v;
    req_addr  = a;
    @(negedge clk);
    chk("req_ready", {28'd0, req_ready}, {28'd0, er});
    if (er != 4'b0000) begin
      chk("rom_addr", {22'd0, rom_addr}, {22'd0, ea});
      if (push) sb.push_back('{tag: er, data: ed, due: cyc + 2});
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [39:0] RR_ADDR = {10'h013, 10'h012, 10'h011, 10'h010};

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_addr  = RR_ADDR;
    repeat (2) @(negedge clk);
    chk("rst_req_ready",  {28'd0, req_ready},  32'd0);
    chk("rst_resp_valid", {28'd0, resp_valid}, 32'd0);
    chk("rst_resp_data",  {16'd0, resp_data},  32'd0);
    chk("rst_busy",       {31'd0, busy},       32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // round-robin with all requesters active
    step(4'hF, RR_ADDR, 4'b0001, 10'h010, 16'h1010, 1'b1);
    step(4'hF, RR_ADDR, 4'b0010, 10'h011, 16'h1011, 1'b1);
    step(4'hF, RR_ADDR, 4'b0100, 10'h012, 16'h1012, 1'b1);
    step(4'hF, RR_ADDR, 4'b1000, 10'h013, 16'h1013, 1'b1);
    step(4'hF, RR_ADDR, 4'b0001, 10'h010, 16'h1010, 1'b1);
    step(4'hF, RR_ADDR, 4'b0010, 10'h011, 16'h1011, 1'b1);

    // single read from requester 2
    step(4'b0100, {10'h0, 10'h025, 20'h0}, 4'b0100, 10'h025, 16'h1025, 1'b1);
    step(4'b0000, 40'h0, 4'b0000, 10'h0, 16'h0, 1'b0);
    step(4'b0000, 40'h0, 4'b0000, 10'h0, 16'h0, 1'b0);
    chk("hold_after_single", {16'd0, resp_data}, 32'h1025);
    chk("idle_rom_addr",     {22'd0, rom_addr},  32'h025);

    // skip and wrap: grant 3, then only 1 and 2
    step(4'b1000, {10'h077, 30'h0}, 4'b1000, 10'h077, 16'h1077, 1'b1);
    step(4'b0110, {10'h0, 10'h032, 10'h031, 10'h0}, 4'b0010, 10'h031, 16'h1031, 1'b1);
    step(4'b0110, {10'h0, 10'h032, 10'h031, 10'h0}, 4'b0100, 10'h032, 16'h1032, 1'b1);
    step(4'b0110, {10'h0, 10'h032, 10'h031, 10'h0}, 4'b0010, 10'h031, 16'h1031, 1'b1);

    // idle hold after a top-of-range read
    step(4'b0100, {10'h0, 10'h3FF, 20'h0}, 4'b0100, 10'h3FF, 16'h13FF, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      req_valid = 4'b0000;
      req_addr  = 40'h0;
      @(negedge clk);
      chk("idle_ready",    {28'd0, req_ready}, 32'd0);
      chk("idle_rom_addr", {22'd0, rom_addr},  32'h3FF);
      chk("idle_busy",     {31'd0, busy},      (i <= 2) ? 32'd1 : 32'd0);
      if (i >= 3) chk("idle_resp_data", {16'd0, resp_data}, 32'h13FF);
      @(posedge clk);
      #1;
    end

    // reset while a read is in flight: ptr is 3 here
    step(4'b1000, {10'h055, 30'h0}, 4'b1000, 10'h055, 16'h1055, 1'b0);
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_resp_valid", {28'd0, resp_valid}, 32'd0);
    chk("midrst_busy",       {31'd0, busy},       32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_resp_valid", {28'd0, resp_valid}, 32'd0);
    chk("post_rst_resp_data",  {16'd0, resp_data},  32'd0);
    @(posedge clk);
    #1;
    step(4'hF, RR_ADDR, 4'b0001, 10'h010, 16'h1010, 1'b1);
    step(4'hF, RR_ADDR, 4'b0010, 10'h011, 16'h1011, 1'b1);
    step(4'b0000, 40'h0, 4'b0000, 10'h0, 16'h0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
